// File: rtl/up3_ctrl_if.sv
// -----------------------------------------------------------------------------
// up3_ctrl_if -- controller <-> datapath bundle for the UP3 processor.
//
// Signals
//   ir_upper   [7:0]  instruction register upper byte (opcode in [4:0])
//   ZFLG, NFLG        ALU zero / negative flags, combinational from datapath
//   STORE_MEM         write AC to MEM[addr]
//   FETCH             RAM address mux selects PC (1) or ir_lower (0)
//   INCR_PC           PC <- PC + 1
//   LOAD_PC           PC <- ir_lower
//   LOAD_IRL          IRL <- RAM output
//   LOAD_IRU          IRU <- RAM output
//   LOAD_AC           AC <- ALU result
//
// Strobe semantics: there is no valid/ready pair on this bundle. Every strobe
// is a single-cycle qualifier that the datapath acts on at the rising clk edge
// that ends the cycle in which it is high; nothing is ever held or
// back-pressured.
//
// Modports
//   master  the controller: reads instruction/flags, drives strobes
//   slave   the datapath: drives instruction/flags, reads strobes
// -----------------------------------------------------------------------------
interface up3_ctrl_if;
   logic [7:0] ir_upper;
   logic       ZFLG;
   logic       NFLG;
   logic       STORE_MEM;
   logic       FETCH;
   logic       INCR_PC;
   logic       LOAD_PC;
   logic       LOAD_IRL;
   logic       LOAD_IRU;
   logic       LOAD_AC;

   modport master (
      input  ir_upper, ZFLG, NFLG,
      output STORE_MEM, FETCH, INCR_PC, LOAD_PC, LOAD_IRL, LOAD_IRU, LOAD_AC
   );

   modport slave (
      output ir_upper, ZFLG, NFLG,
      input  STORE_MEM, FETCH, INCR_PC, LOAD_PC, LOAD_IRL, LOAD_IRU, LOAD_AC
   );
endinterface

// File: rtl/up3_ctrl.sv
// -----------------------------------------------------------------------------
// up3_ctrl -- instruction sequencer for the UP3 accumulator processor.
//
// Each instruction is two bytes (opcode at PC, operand at PC+1) fetched from a
// RAM with one cycle of registered read latency. The FSM walks
// IDLE -> F1 -> F2 -> F3 -> DEC [-> EXM] -> F1 ... and parks in HALT on the
// HALT opcode until reset.
//
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous, active-low
//   run       level; leaves IDLE when high (sampled only in IDLE)
//   bus       up3_ctrl_if.master: instruction byte, flags and datapath strobes
//   state     current FSM state (IDLE=0 F1=1 F2=2 F3=3 DEC=4 EXM=5 HALT=6)
//   halted    high while in HALT
//   illegal   one-cycle pulse in DEC for opcodes 5'h1C..5'h1E
//
// All outputs are decoded combinationally from the state register (and, in
// DEC, from the opcode and flags), so the asynchronous reset clears them
// immediately without waiting for a clock edge.
// -----------------------------------------------------------------------------
module up3_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
   up3_ctrl_if.master  bus,
   output logic [2:0]  state,
   output logic        halted,
   output logic        illegal
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_F1   = 3'd1,
      S_F2   = 3'd2,
      S_F3   = 3'd3,
      S_DEC  = 3'd4,
      S_EXM  = 3'd5,
      S_HALT = 3'd6
   } state_t;

   state_t     state_q;
   state_t     state_d;
   logic [4:0] opcode;
   logic       unused_ir_hi;

   logic store_c, fetch_c, incr_c, load_pc_c, load_irl_c, load_iru_c, load_ac_c;
   logic illegal_c;

   // Bits [7:5] of the upper instruction byte carry no meaning for control.
   assign opcode       = bus.ir_upper[4:0];
   assign unused_ir_hi = ^bus.ir_upper[7:5];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      store_c    = 1'b0;
      fetch_c    = 1'b0;
      incr_c     = 1'b0;
      load_pc_c  = 1'b0;
      load_irl_c = 1'b0;
      load_iru_c = 1'b0;
      load_ac_c  = 1'b0;
      illegal_c  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (run) state_d = S_F1;
         end
         // F1: RAM captures PC (opcode address); PC advances to operand.
         S_F1: begin
            fetch_c = 1'b1;
            incr_c  = 1'b1;
            state_d = S_F2;
         end
         // F2: opcode byte is now on the RAM output; RAM captures PC0+1.
         S_F2: begin
            fetch_c    = 1'b1;
            incr_c     = 1'b1;
            load_iru_c = 1'b1;
            state_d    = S_F3;
         end
         S_F3: begin
            fetch_c    = 1'b1;
            load_irl_c = 1'b1;
            state_d    = S_DEC;
         end
         // DEC: FETCH=0 points the RAM at ir_lower so a memory operand is
         // ready in EXM. Decode is Mealy on opcode and the live flags.
         S_DEC: begin
            state_d = S_F1;
            case (opcode) inside
               5'h00:          state_d = S_F1;
               [5'h01:5'h0F]:  state_d = S_EXM;
               [5'h10:5'h17]:  load_ac_c = 1'b1;
               5'h18:          store_c = 1'b1;
               5'h19:          load_pc_c = 1'b1;
               5'h1A:          load_pc_c = bus.ZFLG;
               5'h1B:          load_pc_c = bus.NFLG;
               [5'h1C:5'h1E]:  illegal_c = 1'b1;
               5'h1F:          state_d = S_HALT;
               default:        state_d = S_F1;
            endcase
         end
         S_EXM: begin
            load_ac_c = 1'b1;
            state_d   = S_F1;
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.STORE_MEM = store_c;
   assign bus.FETCH     = fetch_c;
   assign bus.INCR_PC   = incr_c;
   assign bus.LOAD_PC   = load_pc_c;
   assign bus.LOAD_IRL  = load_irl_c;
   assign bus.LOAD_IRU  = load_iru_c;
   assign bus.LOAD_AC   = load_ac_c;

   assign state   = state_q;
   assign halted  = (state_q == S_HALT);
   assign illegal = illegal_c;

endmodule

// File: tb/tb_up3_ctrl.sv
// -----------------------------------------------------------------------------
// tb_up3_ctrl -- directed scoreboard bench for up3_ctrl.
//
// The driver advances one cycle at a time and, for each cycle, pushes the
// expected output vector {state, STORE_MEM, FETCH, INCR_PC, LOAD_PC, LOAD_IRL,
// LOAD_IRU, LOAD_AC, halted, illegal}. The monitor samples on the falling edge
// and pops one entry per cycle. A protocol checker tests the strobe exclusion
// rules on every falling edge. Asynchronous-reset behaviour is checked
// directly between edges.
// -----------------------------------------------------------------------------
module tb_up3_ctrl;

   localparam int W = 12;

   // strobe bit order: STORE_MEM FETCH INCR_PC LOAD_PC LOAD_IRL LOAD_IRU LOAD_AC
   localparam logic [6:0] SB_NONE  = 7'b0000000;
   localparam logic [6:0] SB_F1    = 7'b0110000;
   localparam logic [6:0] SB_F2    = 7'b0110010;
   localparam logic [6:0] SB_F3    = 7'b0100100;
   localparam logic [6:0] SB_AC    = 7'b0000001;
   localparam logic [6:0] SB_PC    = 7'b0001000;
   localparam logic [6:0] SB_STORE = 7'b1000000;

   logic       clk;
   logic       reset;
   logic       run;
   logic [2:0] state;
   logic       halted;
   logic       illegal;

   up3_ctrl_if bus ();

   up3_ctrl dut (
      .clk     (clk),
      .reset   (reset),
      .run     (run),
      .bus     (bus),
      .state   (state),
      .halted  (halted),
      .illegal (illegal)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   logic [W-1:0] exp_q[$];
   string        name_q[$];
   int           checks = 0;
   int           errors = 0;

   function automatic logic [W-1:0] mk(input logic [2:0] st, input logic [6:0] sb,
                                       input logic h, input logic il);
      return {st, sb, h, il};
   endfunction

   function automatic logic [W-1:0] actual_vec();
      return {state, bus.STORE_MEM, bus.FETCH, bus.INCR_PC, bus.LOAD_PC,
              bus.LOAD_IRL, bus.LOAD_IRU, bus.LOAD_AC, halted, illegal};
   endfunction

   task automatic check_now(input string nm, input logic [W-1:0] exp);
      logic [W-1:0] act;
      act = actual_vec();
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %03h expected %03h", nm, act, exp);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [W-1:0] e;
      logic [W-1:0] a;
      string        nm;
      if (exp_q.size() > 0) begin
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         a  = actual_vec();
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL %s: got %03h expected %03h", nm, a, e);
         end
      end
   end

   // ---------------- protocol checker ----------------
   always @(negedge clk) begin
      if (reset) begin
         checks++;
         if ((bus.INCR_PC && bus.LOAD_PC) || (bus.STORE_MEM && bus.FETCH) ||
             (int'(bus.LOAD_IRU) + int'(bus.LOAD_IRL) + int'(bus.LOAD_AC) > 1)) begin
            errors++;
            $display("FAIL protocol at %0t: state %0d strobes %07b", $time, state,
                     {bus.STORE_MEM, bus.FETCH, bus.INCR_PC, bus.LOAD_PC,
                      bus.LOAD_IRL, bus.LOAD_IRU, bus.LOAD_AC});
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called at posedge+1: queue the expectation for this cycle, then move on.
   task automatic step(input logic [W-1:0] exp, input string nm);
      exp_q.push_back(exp);
      name_q.push_back(nm);
      @(posedge clk);
      #1;
   endtask

   // Entered in F1; leaves in the cycle after DEC (or EXM).
   task automatic exec(input logic [7:0] ir, input logic z, input logic n,
                       input logic [6:0] dec_sb, input logic il, input bit exm,
                       input bit drop_run, input string nm);
      bus.ir_upper = ir;
      bus.ZFLG     = ~z;    // flags are wrong outside DEC on purpose
      bus.NFLG     = ~n;
      step(mk(3'd1, SB_F1, 1'b0, 1'b0), {nm, "_f1"});
      if (drop_run) run = 1'b0;
      step(mk(3'd2, SB_F2, 1'b0, 1'b0), {nm, "_f2"});
      step(mk(3'd3, SB_F3, 1'b0, 1'b0), {nm, "_f3"});
      bus.ZFLG = z;
      bus.NFLG = n;
      step(mk(3'd4, dec_sb, 1'b0, il), {nm, "_dec"});
      if (exm) step(mk(3'd5, SB_AC, 1'b0, 1'b0), {nm, "_exm"});
      run = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset        = 1'b0;
      run          = 1'b0;
      bus.ir_upper = 8'h00;
      bus.ZFLG     = 1'b0;
      bus.NFLG     = 1'b0;
      #2;
      check_now("reset_state", mk(3'd0, SB_NONE, 1'b0, 1'b0));
      @(posedge clk); #1;
      step(mk(3'd0, SB_NONE, 1'b0, 1'b0), "reset_hold");
      reset = 1'b1;
      step(mk(3'd0, SB_NONE, 1'b0, 1'b0), "idle_run0");
      step(mk(3'd0, SB_NONE, 1'b0, 1'b0), "idle_run0_b");
      run = 1'b1;
      step(mk(3'd0, SB_NONE, 1'b0, 1'b0), "idle_run1");

      exec(8'h10, 1'b0, 1'b0, SB_AC,    1'b0, 1'b0, 1'b0, "imm10");
      exec(8'h03, 1'b0, 1'b0, SB_NONE,  1'b0, 1'b1, 1'b0, "mem03");
      exec(8'h1A, 1'b1, 1'b0, SB_PC,    1'b0, 1'b0, 1'b0, "jz_z1");
      exec(8'h1A, 1'b0, 1'b1, SB_NONE,  1'b0, 1'b0, 1'b0, "jz_z0");
      exec(8'h1B, 1'b0, 1'b1, SB_PC,    1'b0, 1'b0, 1'b0, "jn_n1");
      exec(8'h1B, 1'b1, 1'b0, SB_NONE,  1'b0, 1'b0, 1'b0, "jn_n0");
      exec(8'h18, 1'b0, 1'b0, SB_STORE, 1'b0, 1'b0, 1'b0, "store");
      exec(8'h1D, 1'b0, 1'b0, SB_NONE,  1'b1, 1'b0, 1'b0, "illegal1d");
      exec(8'h00, 1'b1, 1'b1, SB_NONE,  1'b0, 1'b0, 1'b0, "nop");
      exec(8'h19, 1'b0, 1'b0, SB_PC,    1'b0, 1'b0, 1'b0, "jmp");
      exec(8'hF7, 1'b0, 1'b0, SB_AC,    1'b0, 1'b0, 1'b0, "imm17_hi");
      exec(8'hE3, 1'b0, 1'b0, SB_NONE,  1'b0, 1'b1, 1'b1, "mem03_hi_run0");
      exec(8'h0F, 1'b0, 1'b0, SB_NONE,  1'b0, 1'b1, 1'b1, "mem0f_run0");
      exec(8'h1C, 1'b1, 1'b1, SB_NONE,  1'b1, 1'b0, 1'b0, "illegal1c");
      exec(8'h1F, 1'b1, 1'b1, SB_NONE,  1'b0, 1'b0, 1'b0, "halt_dec");

      for (int i = 0; i < 22; i++) begin
         run = i[0];
         bus.ir_upper = 8'h10;
         step(mk(3'd6, SB_NONE, 1'b1, 1'b0), "halt_hold");
      end

      // asynchronous reset out of HALT, between edges
      #2 reset = 1'b0;
      #1 check_now("halt_async_reset", mk(3'd0, SB_NONE, 1'b0, 1'b0));
      @(posedge clk); #1;
      run = 1'b0;
      reset = 1'b1;
      step(mk(3'd0, SB_NONE, 1'b0, 1'b0), "post_halt_idle");
      run = 1'b1;
      step(mk(3'd0, SB_NONE, 1'b0, 1'b0), "post_halt_run");
      bus.ir_upper = 8'h10;
      step(mk(3'd1, SB_F1, 1'b0, 1'b0), "pre_abort_f1");

      // now in F2: pulse reset low mid-cycle
      check_now("abort_in_f2", mk(3'd2, SB_F2, 1'b0, 1'b0));
      #2 reset = 1'b0;
      #1 check_now("abort_async", mk(3'd0, SB_NONE, 1'b0, 1'b0));
      #1 reset = 1'b1;
      run = 1'b0;
      @(posedge clk); #1;
      step(mk(3'd0, SB_NONE, 1'b0, 1'b0), "abort_idle_run0");
      step(mk(3'd0, SB_NONE, 1'b0, 1'b0), "abort_idle_run0_b");
      run = 1'b1;
      step(mk(3'd0, SB_NONE, 1'b0, 1'b0), "abort_idle_run1");
      exec(8'h10, 1'b0, 1'b0, SB_AC, 1'b0, 1'b0, 1'b0, "restart_imm");
      step(mk(3'd1, SB_F1, 1'b0, 1'b0), "restart_next_f1");

      @(negedge clk); #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain: got %0d entries left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // hard stop in case stimulus never completes
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within 200000 time units");
      $fatal(1, "timeout");
   end

endmodule
